// File: rtl/alu_pkg.sv
// alu_pkg: opcode encodings and flag bit positions shared by the ALU core and its bench
package alu_pkg;
  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_SHL  = 4'h2,
    OP_SHR  = 4'h3,
    OP_PASS = 4'h4,
    OP_AND  = 4'h5,
    OP_OR   = 4'h6,
    OP_XOR  = 4'h7,
    OP_NAND = 4'h8,
    OP_NOR  = 4'h9,
    OP_XNOR = 4'hA,
    OP_NOT  = 4'hB,
    OP_NEG  = 4'hC,
    OP_MUL  = 4'hD,
    OP_SWAP = 4'hE,
    OP_LOAD = 4'hF
  } op_e;
  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;
endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: unsigned shift-add multiplier, one multiplier bit per cycle
module alu_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH + 1);
  logic [2*WIDTH-1:0] mcand_q, mcand_d, acc_q, acc_d, addend;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               busy_q, busy_d;
  assign addend  = mplier_q[0] ? mcand_q : '0;
  assign product = acc_q + addend;
  assign busy    = busy_q;
  assign done    = busy_q && (cnt_q == CW'(1));
  // load operands on start, otherwise accumulate one partial product per cycle
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    if (start) begin
      mcand_d  = {{WIDTH{1'b0}}, a};
      mplier_d = b;
      acc_d    = '0;
      cnt_d    = CW'(WIDTH);
      busy_d   = 1'b1;
    end else if (busy_q) begin
      acc_d    = product;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CW'(1);
      busy_d   = cnt_q != CW'(1);
    end
  end
  // state register; reset aborts any multiplication in flight
  always_ff @(posedge clock) begin
    if (reset) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end
endmodule

// File: rtl/alu_regfile_core.sv
// alu_regfile_core: register file plus ALU with single-cycle ops and a sequential multiplier
module alu_regfile_core
  import alu_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int NUM_REGS = 4,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             op_valid,
  output logic             ready,
  input  logic [3:0]       opcode,
  input  logic [AW-1:0]    src_a,
  input  logic [AW-1:0]    src_b,
  input  logic [AW-1:0]    dst,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_hi,
  output logic [3:0]       flags,
  output logic             busy,
  output logic             done,
  output logic             overrun
);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  logic [WIDTH-1:0]   regs_q [NUM_REGS];
  logic [WIDTH-1:0]   regs_d [NUM_REGS];
  logic [WIDTH-1:0]   y_q, y_d, y_hi_q, y_hi_d;
  logic [3:0]         flags_q, flags_d;
  logic [AW-1:0]      dst_q, dst_d;
  logic               done_q, done_d, overrun_q, overrun_d;
  logic [WIDTH-1:0]   a, b, res;
  logic [WIDTH:0]     sum, diff;
  logic               c, v, accept, mul_start, mul_busy, mul_done;
  logic [2*WIDTH-1:0] product;
  op_e                op;
  assign op        = op_e'(opcode);
  assign a         = regs_q[src_a];
  assign b         = regs_q[src_b];
  assign accept    = op_valid && !mul_busy;
  assign mul_start = accept && (op == OP_MUL);
  assign ready     = !mul_busy;
  assign busy      = mul_busy;
  assign y         = y_q;
  assign y_hi      = y_hi_q;
  assign flags     = flags_q;
  assign done      = done_q;
  assign overrun   = overrun_q;
  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clock   (clock),
    .reset   (reset),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (product)
  );
  // single-cycle result with carry/borrow and overflow for the flag-updating ops
  always_comb begin
    sum  = {1'b0, a} + {1'b0, b};
    diff = {1'b0, a} - {1'b0, b};
    res  = '0;
    c    = 1'b0;
    v    = 1'b0;
    case (op)
      OP_ADD: begin
        res = sum[WIDTH-1:0];
        c   = sum[WIDTH];
        v   = (a[WIDTH-1] == b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        res = diff[WIDTH-1:0];
        c   = diff[WIDTH];
        v   = (a[WIDTH-1] != b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SHL: begin
        res = {a[WIDTH-2:0], 1'b0};
        c   = a[WIDTH-1];
      end
      OP_SHR: begin
        res = {1'b0, a[WIDTH-1:1]};
        c   = a[0];
      end
      OP_PASS: res = a;
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_NAND: res = ~(a & b);
      OP_NOR:  res = ~(a | b);
      OP_XNOR: res = ~(a ^ b);
      OP_NOT:  res = ~a;
      OP_NEG: begin
        res = -a;
        v   = a == MIN_NEG;
      end
      default: res = '0;
    endcase
  end
  // architectural update: multiplier completion, or an accepted request; busy requests only flag overrun
  always_comb begin
    regs_d    = regs_q;
    y_d       = y_q;
    y_hi_d    = y_hi_q;
    flags_d   = flags_q;
    dst_d     = dst_q;
    done_d    = 1'b0;
    overrun_d = overrun_q || (op_valid && mul_busy);
    if (mul_done) begin
      regs_d[dst_q]   = product[WIDTH-1:0];
      y_d             = product[WIDTH-1:0];
      y_hi_d          = product[2*WIDTH-1:WIDTH];
      flags_d[FLAG_Z] = product[WIDTH-1:0] == '0;
      flags_d[FLAG_N] = product[WIDTH-1];
      flags_d[FLAG_C] = |product[2*WIDTH-1:WIDTH];
      flags_d[FLAG_V] = |product[2*WIDTH-1:WIDTH];
      done_d          = 1'b1;
    end else if (accept) begin
      done_d = op != OP_MUL;
      dst_d  = dst;
      if (op == OP_SWAP) begin
        regs_d[src_a] = b;
        regs_d[src_b] = a;
      end else if (op == OP_LOAD) begin
        regs_d[dst] = data_in;
      end else if (op != OP_MUL) begin
        regs_d[dst]     = res;
        y_d             = res;
        y_hi_d          = '0;
        flags_d[FLAG_Z] = res == '0;
        flags_d[FLAG_N] = res[WIDTH-1];
        flags_d[FLAG_C] = c;
        flags_d[FLAG_V] = v;
      end
    end
  end
  // state register with synchronous reset taking priority over any request
  always_ff @(posedge clock) begin
    if (reset) begin
      regs_q    <= '{default: '0};
      y_q       <= '0;
      y_hi_q    <= '0;
      flags_q   <= '0;
      dst_q     <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      regs_q    <= regs_d;
      y_q       <= y_d;
      y_hi_q    <= y_hi_d;
      flags_q   <= flags_d;
      dst_q     <= dst_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end
endmodule
